// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant of up to two writes per cycle onto ports A/B,
// plus a per-register busy scoreboard. Optional stall counter under CV32E40P_RF_WB_ARB_PERF_EN.
module cv32e40p_rf_wb_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int N_REQ      = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_REQ-1:0]               req_valid_i,
   input  logic [N_REQ*ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [N_REQ*DATA_WIDTH-1:0]    req_data_i,
   output logic [N_REQ-1:0]               req_ready_o,
   input  logic                           rsv_valid_i,
   input  logic [ADDR_WIDTH-1:0]          rsv_addr_i,
   output logic [2**ADDR_WIDTH-1:0]       busy_o,
   output logic [ADDR_WIDTH-1:0]          waddr_a_o,
   output logic [DATA_WIDTH-1:0]          wdata_a_o,
   output logic                           we_a_o,
   output logic [ADDR_WIDTH-1:0]          waddr_b_o,
   output logic [DATA_WIDTH-1:0]          wdata_b_o,
   output logic                           we_b_o
`ifdef CV32E40P_RF_WB_ARB_PERF_EN
   ,
   output logic [15:0]                    stall_cnt_o
`endif
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   function automatic logic [PTR_W-1:0] wrap_idx(input int v);
      int r;
      r = v;
      if (r >= N_REQ) r = r - N_REQ;
      return r[PTR_W-1:0];
   endfunction

   logic [ADDR_WIDTH-1:0]   addr_arr [N_REQ];
   logic [DATA_WIDTH-1:0]   data_arr [N_REQ];
   logic [PTR_W-1:0]        rr_ptr;
   logic [PTR_W-1:0]        scan_idx_p0;
   logic [PTR_W-1:0]        idx_a_p0;
   logic [PTR_W-1:0]        idx_b_p0;
   logic                    gnt_a_p0;
   logic                    gnt_b_p0;
   logic [2**ADDR_WIDTH-1:0] busy_nxt;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // ---- stage p0: combinational round-robin scan from rr_ptr ----
   always_comb begin
      req_ready_o = '0;
      gnt_a_p0    = 1'b0;
      gnt_b_p0    = 1'b0;
      idx_a_p0    = '0;
      idx_b_p0    = '0;
      scan_idx_p0 = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_idx_p0 = wrap_idx(int'(rr_ptr) + i);
         if (req_valid_i[scan_idx_p0]) begin
            if (!gnt_a_p0) begin
               gnt_a_p0                 = 1'b1;
               idx_a_p0                 = scan_idx_p0;
               req_ready_o[scan_idx_p0] = 1'b1;
            end else if (!gnt_b_p0 && (addr_arr[scan_idx_p0] != addr_arr[idx_a_p0])) begin
               // a second write to the same register would race on the RF, so it waits
               gnt_b_p0                 = 1'b1;
               idx_b_p0                 = scan_idx_p0;
               req_ready_o[scan_idx_p0] = 1'b1;
            end
         end
      end
   end

   // reservation is applied after the clears so that a same-cycle set wins
   always_comb begin
      busy_nxt = busy_o;
      if (gnt_a_p0) busy_nxt[addr_arr[idx_a_p0]] = 1'b0;
      if (gnt_b_p0) busy_nxt[addr_arr[idx_b_p0]] = 1'b0;
      if (rsv_valid_i && (rsv_addr_i != '0)) busy_nxt[rsv_addr_i] = 1'b1;
   end

   // ---- stage p1: registered register-file port drive ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_a_o    <= 1'b0;
         we_b_o    <= 1'b0;
         waddr_a_o <= '0;
         waddr_b_o <= '0;
         wdata_a_o <= '0;
         wdata_b_o <= '0;
         busy_o    <= '0;
         rr_ptr    <= '0;
      end else begin
         we_a_o <= gnt_a_p0 && (addr_arr[idx_a_p0] != '0);
         we_b_o <= gnt_b_p0 && (addr_arr[idx_b_p0] != '0);
         if (gnt_a_p0) begin
            waddr_a_o <= addr_arr[idx_a_p0];
            wdata_a_o <= data_arr[idx_a_p0];
         end
         if (gnt_b_p0) begin
            waddr_b_o <= addr_arr[idx_b_p0];
            wdata_b_o <= data_arr[idx_b_p0];
         end
         if (gnt_b_p0)      rr_ptr <= wrap_idx(int'(idx_b_p0) + 1);
         else if (gnt_a_p0) rr_ptr <= wrap_idx(int'(idx_a_p0) + 1);
         busy_o <= busy_nxt;
      end
   end

`ifdef CV32E40P_RF_WB_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_o <= '0;
      end else if ((|(req_valid_i & ~req_ready_o)) && (stall_cnt_o != 16'hFFFF)) begin
         stall_cnt_o <= stall_cnt_o + 16'd1;
      end
   end
`endif

endmodule
